ftime_sorter: RTL

FTIME_SORTER -- requirements
Module: ftime_sorter

---
 rtl/wfq_pkg.sv | 42 ++++
 rtl/ftime_sorter_cell.sv | 122 ++++++++++++
 rtl/ftime_sorter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/wfq_pkg.sv
// wfq_pkg -- definitions shared by the WFQ blocks (finish_time, ftime_sorter,
// scheduler).
//
// Contents:
//   TAG_W_DEF / ID_W_DEF : default finish-time tag and flow-id widths
//   MAX_TAG_W            : widest tag that tag_before() can compare
//   sort_op_e            : operation the sorter applies to its slots this cycle
//   cell_sel_e           : source a sorter slot loads on the next edge
//   tag_before()         : modular (wrap-around) "a precedes b" comparison
package wfq_pkg;

  localparam int TAG_W_DEF = 16;
  localparam int ID_W_DEF  = 13;
  localparam int MAX_TAG_W = 64;

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,  // nothing accepted, every slot holds
    OP_INS  = 2'd1,  // insert only
    OP_DEQ  = 2'd2,  // dequeue only
    OP_BOTH = 2'd3   // dequeue head, then insert into the remainder
  } sort_op_e;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,  // keep own entry
    SEL_UP   = 2'd1,  // take the lower neighbour (entries move away from head)
    SEL_DOWN = 2'd2,  // take the upper neighbour (entries move toward head)
    SEL_LOAD = 2'd3   // take the incoming tag
  } cell_sel_e;

  // Tags are sequence numbers that wrap. Because live tags span less than half
  // the tag space, a precedes b exactly when (a - b) mod 2^w has its MSB set.
  // Callers zero-extend their w-bit tags to MAX_TAG_W; the low w bits of the
  // wide difference are the w-bit modular difference.
  function automatic logic tag_before(input logic [MAX_TAG_W-1:0] a,
                                      input logic [MAX_TAG_W-1:0] b,
                                      input int unsigned          w);
    logic [MAX_TAG_W-1:0] diff;
    diff = a - b;
    return 1'(diff >> (w - 1));
  endfunction

endpackage

// File: rtl/ftime_sorter_cell.sv
// ftime_sorter_cell -- one slot of the sorted finish-time register array.
//
// Each slot holds one (valid, tag, flow id) entry and compares its tag with the
// incoming tag. From its own compare result and those of its neighbours it
// chooses to hold, shift up, shift down, or load the incoming entry.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   op_i                   sorter operation this cycle
//   new_tag_i, new_id_i    entry being inserted
//   left_*_i               entry and after-flag of slot i-1 (toward head)
//   right_*_i              entry and after-flag of slot i+1 (toward tail)
//   valid_o, tag_o, id_o   this slot's entry
//   after_o                1 when this slot is valid and its tag does not come
//                          after the incoming one, so the new entry belongs
//                          behind it (ties keep arrival order)
module ftime_sorter_cell
  import wfq_pkg::*;
#(
  parameter int TAG_W   = TAG_W_DEF,
  parameter int ID_W    = ID_W_DEF,
  parameter bit IS_HEAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  sort_op_e         op_i,
  input  logic [TAG_W-1:0] new_tag_i,
  input  logic [ID_W-1:0]  new_id_i,
  input  logic             left_valid_i,
  input  logic [TAG_W-1:0] left_tag_i,
  input  logic [ID_W-1:0]  left_id_i,
  input  logic             left_after_i,
  input  logic             right_valid_i,
  input  logic [TAG_W-1:0] right_tag_i,
  input  logic [ID_W-1:0]  right_id_i,
  input  logic             right_after_i,
  output logic             valid_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [ID_W-1:0]  id_o,
  output logic             after_o
);

  logic             valid_q, valid_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [ID_W-1:0]  id_q, id_d;
  cell_sel_e        sel;

  assign after_o = valid_q &&
                   !tag_before(MAX_TAG_W'(new_tag_i), MAX_TAG_W'(tag_q), TAG_W);

  // The after flags form a prefix of ones across the sorted array, so the
  // insert position is the first slot whose own flag is 0.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    sel = SEL_HOLD;
    unique case (op_i)
      // Slots in front of the insert point hold, the insert point loads and
      // everything behind it moves one slot toward the tail.
      OP_INS: begin
        if (after_o)                     sel = SEL_HOLD;
        else if (IS_HEAD || left_after_i) sel = SEL_LOAD;
        else                              sel = SEL_UP;
      end
      OP_DEQ:  sel = SEL_DOWN;
      // Slot j now represents old slot j+1: entries still in front of the new
      // tag move down, the insert point loads, entries behind it stay put.
      // The head always reloads because its old entry is leaving.
      OP_BOTH: begin
        if (right_after_i)           sel = SEL_DOWN;
        else if (IS_HEAD || after_o) sel = SEL_LOAD;
        else                         sel = SEL_HOLD;
      end
      default: sel = SEL_HOLD;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    id_d    = id_q;
    unique case (sel)
      SEL_UP: begin
        valid_d = left_valid_i;
        tag_d   = left_tag_i;
        id_d    = left_id_i;
      end
      SEL_DOWN: begin
        valid_d = right_valid_i;
        tag_d   = right_tag_i;
        id_d    = right_id_i;
      end
      SEL_LOAD: begin
        valid_d = 1'b1;
        tag_d   = new_tag_i;
        id_d    = new_id_i;
      end
      default: ;
    endcase
  end

  // NOTE: the entry array is reset rather than left to power-up values,
  // because the valid bits define the queue contents.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every slot samples its neighbours'
    // pre-edge values during a shift.
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      id_q    <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      id_q    <= id_d;
    end
  end

  assign valid_o = valid_q;
  assign tag_o   = tag_q;
  assign id_o    = id_q;

endmodule

// File: rtl/ftime_sorter.sv
// ftime_sorter -- sorted queue of WFQ finish-time tags, smallest tag at head.
//
// Inserts are placed in one cycle by parallel compare-and-shift across DEPTH
// slots. Equal tags keep arrival order and comparison is modular. A
// simultaneous insert and dequeue removes the head first and then inserts the
// new tag, which is why that combination is accepted even when the queue is
// full.
//
// Ports:
//   clk, rst_n                clock, synchronous active-low reset
//   in_valid, in_ftime,       one-cycle insert strobe with tag and flow id
//   in_flow_id
//   deq_req                   one-cycle request to pop the head
//   out_valid, out_ftime,     registered dequeue result; the data outputs hold
//   out_flow_id               their value while out_valid is low
//   count, full, empty        registered occupancy
//   drop_err                  one-cycle pulse after an insert is discarded
module ftime_sorter
  import wfq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = TAG_W_DEF,
  parameter int ID_W  = ID_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [TAG_W-1:0]       in_ftime,
  input  logic [ID_W-1:0]        in_flow_id,
  input  logic                   deq_req,
  output logic                   out_valid,
  output logic [TAG_W-1:0]       out_ftime,
  output logic [ID_W-1:0]        out_flow_id,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   drop_err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] slot_valid;
  logic [DEPTH-1:0] slot_after;
  logic [TAG_W-1:0] slot_tag [DEPTH];
  logic [ID_W-1:0]  slot_id  [DEPTH];

  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             out_valid_q, out_valid_d;
  logic [TAG_W-1:0] out_ftime_q, out_ftime_d;
  logic [ID_W-1:0]  out_flow_id_q, out_flow_id_d;
  logic             drop_q, drop_d;

  logic     deq_ok;
  logic     ins_ok;
  sort_op_e op;

  always_comb begin
    // A dequeue on an empty queue is ignored; an insert is refused only when
    // the queue is full and no dequeue frees a slot in the same cycle.
    deq_ok = deq_req && !empty_q;
    ins_ok = in_valid && (!full_q || deq_ok);

    op = OP_IDLE;
    if (ins_ok && deq_ok) op = OP_BOTH;
    else if (ins_ok)      op = OP_INS;
    else if (deq_ok)      op = OP_DEQ;

    count_d = count_q;
    if (ins_ok && !deq_ok)      count_d = count_q + CNT_W'(1);
    else if (deq_ok && !ins_ok) count_d = count_q - CNT_W'(1);
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);

    drop_d = in_valid && full_q && !deq_req;

    out_valid_d   = deq_ok;
    out_ftime_d   = deq_ok ? slot_tag[0] : out_ftime_q;
    out_flow_id_d = deq_ok ? slot_id[0]  : out_flow_id_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q       <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      out_valid_q   <= 1'b0;
      out_ftime_q   <= '0;
      out_flow_id_q <= '0;
      drop_q        <= 1'b0;
    end else begin
      count_q       <= count_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      out_valid_q   <= out_valid_d;
      out_ftime_q   <= out_ftime_d;
      out_flow_id_q <= out_flow_id_d;
      drop_q        <= drop_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic             l_valid, r_valid;
    logic [TAG_W-1:0] l_tag, r_tag;
    logic [ID_W-1:0]  l_id, r_id;
    logic             l_after, r_after;

    // Beyond either end of the array the neighbour is an invalid entry.
    if (i == 0) begin : g_head_edge
      assign l_valid = 1'b0;
      assign l_tag   = '0;
      assign l_id    = '0;
      assign l_after = 1'b1;
    end else begin : g_left
      assign l_valid = slot_valid[i-1];
      assign l_tag   = slot_tag[i-1];
      assign l_id    = slot_id[i-1];
      assign l_after = slot_after[i-1];
    end

    if (i == DEPTH - 1) begin : g_tail_edge
      assign r_valid = 1'b0;
      assign r_tag   = '0;
      assign r_id    = '0;
      assign r_after = 1'b0;
    end else begin : g_right
      assign r_valid = slot_valid[i+1];
      assign r_tag   = slot_tag[i+1];
      assign r_id    = slot_id[i+1];
      assign r_after = slot_after[i+1];
    end

    ftime_sorter_cell #(
      .TAG_W   (TAG_W),
      .ID_W    (ID_W),
      .IS_HEAD (i == 0)
    ) u_cell (
      .clk           (clk),
      .rst_n         (rst_n),
      .op_i          (op),
      .new_tag_i     (in_ftime),
      .new_id_i      (in_flow_id),
      .left_valid_i  (l_valid),
      .left_tag_i    (l_tag),
      .left_id_i     (l_id),
      .left_after_i  (l_after),
      .right_valid_i (r_valid),
      .right_tag_i   (r_tag),
      .right_id_i    (r_id),
      .right_after_i (r_after),
      .valid_o       (slot_valid[i]),
      .tag_o         (slot_tag[i]),
      .id_o          (slot_id[i]),
      .after_o       (slot_after[i])
    );
  end

  assign out_valid   = out_valid_q;
  assign out_ftime   = out_ftime_q;
  assign out_flow_id = out_flow_id_q;
  assign count       = count_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign drop_err    = drop_q;

endmodule
